des_result_fifo: RTL and testbench

Output buffer between the Triple-DES datapath and the AHB-Lite slave read path. It captures each completed 64-bit chunk when the cipher core pulses its done strobe. It holds up to DEPTH chunks in order and returns them one per AHB read-data request. The core can therefore finish chunks faster than the master polls HRDATA without losing results.

---
 rtl/des_pkg.sv | 9 +
 rtl/des_result_mem.sv | 38 +++
 rtl/des_result_fifo.sv | 113 +++++++++++
 tb/tb_des_result_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared Triple-DES types and system-level sizing constants.
package des_pkg;

   localparam int CHUNK_W          = 64;
   localparam int DES_RESULT_DEPTH = 8;

   typedef logic [CHUNK_W-1:0] chunk_t;

endpackage

// File: rtl/des_result_mem.sv
// DEPTH x chunk_t simple dual-port storage: one write port, one registered read port.
module des_result_mem
   import des_pkg::*;
#(
   parameter int DEPTH = DES_RESULT_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [PTR_W-1:0] i_wr_addr,
   input  chunk_t           i_wr_data,
   input  logic             i_rd_en,
   input  logic [PTR_W-1:0] i_rd_addr,
   output chunk_t           o_rd_data
);

   chunk_t r_mem [DEPTH];
   chunk_t r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read-first: a same-address write in this cycle is not visible to the read.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/des_result_fifo.sv
// Result FIFO between the Triple-DES core and the AHB read path.
// Define DES_RESULT_FIFO_ERR_EN to add the sticky overflow/underflow err output.
module des_result_fifo
   import des_pkg::*;
#(
   parameter int DEPTH = DES_RESULT_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic           HCLK,
   input  logic           HRESET,
   input  logic           clear,
   input  logic           push,
   input  chunk_t         push_data,
   input  logic           pop,
   output chunk_t         pop_data,
   output logic           pop_valid,
   output logic [PTR_W:0] count,
   output logic           full,
   output logic           empty
`ifdef DES_RESULT_FIFO_ERR_EN
   ,
   output logic           err
`endif
);

   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [PTR_W:0]   r_count;
   logic             r_pop_valid;

   logic w_full;
   logic w_empty;
   logic w_push_acc;
   logic w_pop_acc;

   assign w_full  = (r_count == CNT_MAX);
   assign w_empty = (r_count == '0);

   // A pop on an empty FIFO is rejected even if a push arrives alongside it.
   assign w_pop_acc  = pop && !w_empty && !clear;
   assign w_push_acc = push && !clear && (!w_full || w_pop_acc);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_wp        <= '0;
         r_rp        <= '0;
         r_count     <= '0;
         r_pop_valid <= 1'b0;
      end else if (clear) begin
         r_wp        <= '0;
         r_rp        <= '0;
         r_count     <= '0;
         r_pop_valid <= 1'b0;
      end else begin
         r_pop_valid <= w_pop_acc;
         if (w_push_acc) begin
            r_wp <= r_wp + PTR_ONE;
         end
         if (w_pop_acc) begin
            r_rp <= r_rp + PTR_ONE;
         end
         if (w_push_acc && !w_pop_acc) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop_acc && !w_push_acc) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   des_result_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .i_clk     (HCLK),
      .i_rst     (HRESET),
      .i_wr_en   (w_push_acc),
      .i_wr_addr (r_wp),
      .i_wr_data (push_data),
      .i_rd_en   (w_pop_acc),
      .i_rd_addr (r_rp),
      .o_rd_data (pop_data)
   );

`ifdef DES_RESULT_FIFO_ERR_EN
   logic r_err;
   logic w_overflow;
   logic w_underflow;

   assign w_overflow  = push && !clear && !w_push_acc;
   assign w_underflow = pop && !clear && !w_pop_acc;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_err <= 1'b0;
      end else if (clear) begin
         r_err <= 1'b0;
      end else if (w_overflow || w_underflow) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

   assign pop_valid = r_pop_valid;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;

endmodule

// File: tb/tb_des_result_fifo.sv
// Scoreboard bench for des_result_fifo: popped data checked against a FIFO model.
module tb_des_result_fifo;
   import des_pkg::*;

   localparam int DEPTH = 8;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        clear;
   logic        push;
   chunk_t      push_data;
   logic        pop;
   chunk_t      pop_data;
   logic        pop_valid;
   logic [3:0]  count;
   logic        full;
   logic        empty;
`ifdef DES_RESULT_FIFO_ERR_EN
   logic        err;
`endif

   always #5 HCLK = ~HCLK;

   des_result_fifo #(.DEPTH(DEPTH)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .clear     (clear),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .count     (count),
      .full      (full),
      .empty     (empty)
`ifdef DES_RESULT_FIFO_ERR_EN
      ,
      .err       (err)
`endif
   );

   chunk_t mdl_q[$];
   chunk_t exp_q[$];
   logic   mdl_err;
   int     pass_cnt  = 0;
   int     total_cnt = 0;

   // Monitor: every pop_valid pulse must match the oldest expected result.
   always @(negedge HCLK) begin
      if (!HRESET && pop_valid) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_pop got %h required no pop_valid", pop_data);
         end else begin
            chunk_t e;
            e = exp_q.pop_front();
            if (pop_data !== e) $display("FAIL sb_pop_data got %h required %h", pop_data, e);
            else pass_cnt++;
         end
      end
   end

   // One cycle of stimulus; the model decides acceptance and queues expected pops.
   task automatic drive(input logic p, input chunk_t pd, input logic po, input logic clr);
      bit pop_acc;
      bit push_acc;
      push = p; push_data = pd; pop = po; clear = clr;
      pop_acc  = 0;
      push_acc = 0;
      if (clr) begin
         mdl_q.delete();
         mdl_err = 1'b0;
      end else begin
         pop_acc  = po && (mdl_q.size() > 0);
         push_acc = p && ((mdl_q.size() < DEPTH) || pop_acc);
         if (pop_acc) exp_q.push_back(mdl_q.pop_front());
         if (push_acc) mdl_q.push_back(pd);
         if ((p && !push_acc) || (po && !pop_acc)) mdl_err = 1'b1;
      end
      @(posedge HCLK); #1;
      push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
      $display("txn t=%0t push=%0b data=%h pop=%0b clear=%0b -> count=%0d pop_valid=%0b pop_data=%h",
               $time, p, pd, po, clr, count, pop_valid, pop_data);
   endtask

   task automatic test_reset();
      HRESET = 1'b1; clear = 0; push = 0; pop = 0; push_data = '0; mdl_err = 0;
      repeat (2) @(posedge HCLK);
      #1 HRESET = 1'b0;
      total_cnt++; if (pop_data !== 64'h0) $display("FAIL rst_pop_data got %h required 0", pop_data); else pass_cnt++;
      total_cnt++; if (pop_valid !== 1'b0) $display("FAIL rst_pop_valid got %b required 0", pop_valid); else pass_cnt++;
      total_cnt++; if (count !== 4'd0) $display("FAIL rst_count got %0d required 0", count); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL rst_full got %b required 0", full); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL rst_empty got %b required 1", empty); else pass_cnt++;
`ifdef DES_RESULT_FIFO_ERR_EN
      total_cnt++; if (err !== 1'b0) $display("FAIL rst_err got %b required 0", err); else pass_cnt++;
`endif
   endtask

   task automatic test_basic();
      drive(1, 64'h8fe0d9c6b3674857, 0, 0);
      drive(1, 64'h0ec42b5c22a87f17, 0, 0);
      total_cnt++; if (count !== 4'd2) $display("FAIL basic_count got %0d required 2", count); else pass_cnt++;
      total_cnt++; if (empty !== 1'b0) $display("FAIL basic_empty got %b required 0", empty); else pass_cnt++;
      drive(0, '0, 1, 0);
      total_cnt++; if (pop_valid !== 1'b1) $display("FAIL basic_pv1 got %b required 1", pop_valid); else pass_cnt++;
      total_cnt++; if (pop_data !== 64'h8fe0d9c6b3674857) $display("FAIL basic_d1 got %h required 8fe0d9c6b3674857", pop_data); else pass_cnt++;
      drive(0, '0, 1, 0);
      total_cnt++; if (pop_valid !== 1'b1) $display("FAIL basic_pv2 got %b required 1", pop_valid); else pass_cnt++;
      total_cnt++; if (pop_data !== 64'h0ec42b5c22a87f17) $display("FAIL basic_d2 got %h required 0ec42b5c22a87f17", pop_data); else pass_cnt++;
      drive(0, '0, 0, 0);
      total_cnt++; if (pop_valid !== 1'b0) $display("FAIL basic_pv_drop got %b required 0", pop_valid); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL basic_empty_end got %b required 1", empty); else pass_cnt++;
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= DEPTH; i++) drive(1, chunk_t'(i), 0, 0);
      total_cnt++; if (full !== 1'b1) $display("FAIL ovf_full got %b required 1", full); else pass_cnt++;
      total_cnt++; if (count !== 4'd8) $display("FAIL ovf_count got %0d required 8", count); else pass_cnt++;
      drive(1, 64'h9, 0, 0);
      total_cnt++; if (count !== 4'd8) $display("FAIL ovf_drop_count got %0d required 8", count); else pass_cnt++;
`ifdef DES_RESULT_FIFO_ERR_EN
      total_cnt++; if (err !== 1'b1) $display("FAIL ovf_err got %b required 1", err); else pass_cnt++;
`endif
      for (int i = 1; i <= DEPTH; i++) begin
         drive(0, '0, 1, 0);
         total_cnt++;
         if (count !== 4'(DEPTH - i)) $display("FAIL ovf_drain_count got %0d required %0d", count, DEPTH - i);
         else pass_cnt++;
      end
      total_cnt++; if (pop_data !== 64'h8) $display("FAIL ovf_last got %h required 8", pop_data); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL ovf_empty got %b required 1", empty); else pass_cnt++;
   endtask

   task automatic test_full_push_pop();
      for (int i = 1; i <= DEPTH; i++) drive(1, chunk_t'(64'h20 + i), 0, 0);
      drive(1, 64'hA, 1, 0);
      total_cnt++; if (count !== 4'd8) $display("FAIL fpp_count got %0d required 8", count); else pass_cnt++;
      total_cnt++; if (pop_valid !== 1'b1) $display("FAIL fpp_pv got %b required 1", pop_valid); else pass_cnt++;
      total_cnt++; if (pop_data !== 64'h21) $display("FAIL fpp_oldest got %h required 21", pop_data); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 0);
      total_cnt++; if (pop_data !== 64'hA) $display("FAIL fpp_last got %h required a", pop_data); else pass_cnt++;
   endtask

   task automatic test_underflow_clear();
      drive(0, '0, 1, 0);
      total_cnt++; if (pop_valid !== 1'b0) $display("FAIL unf_pv got %b required 0", pop_valid); else pass_cnt++;
      total_cnt++; if (pop_data !== 64'hA) $display("FAIL unf_hold got %h required a", pop_data); else pass_cnt++;
`ifdef DES_RESULT_FIFO_ERR_EN
      total_cnt++; if (err !== 1'b1) $display("FAIL unf_err got %b required 1", err); else pass_cnt++;
`endif
      // Push+pop on empty: push taken, pop rejected (no fall-through).
      drive(1, 64'h55, 1, 0);
      total_cnt++; if (pop_valid !== 1'b0) $display("FAIL unf_nofall_pv got %b required 0", pop_valid); else pass_cnt++;
      total_cnt++; if (count !== 4'd1) $display("FAIL unf_nofall_count got %0d required 1", count); else pass_cnt++;
      drive(1, 64'h56, 0, 0);
      drive(1, 64'h57, 1, 1);
      total_cnt++; if (count !== 4'd0) $display("FAIL clr_count got %0d required 0", count); else pass_cnt++;
      total_cnt++; if (pop_valid !== 1'b0) $display("FAIL clr_pv got %b required 0", pop_valid); else pass_cnt++;
      total_cnt++; if (pop_data !== 64'hA) $display("FAIL clr_hold got %h required a", pop_data); else pass_cnt++;
`ifdef DES_RESULT_FIFO_ERR_EN
      total_cnt++; if (err !== 1'b0) $display("FAIL clr_err got %b required 0", err); else pass_cnt++;
`endif
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) begin
         drive((i % 3) != 2, chunk_t'(64'h100 + i), (i % 2) == 1, 0);
         total_cnt++;
         if (count !== 4'(mdl_q.size()) || count > 4'd8)
            $display("FAIL wrap_count got %0d required %0d", count, mdl_q.size());
         else pass_cnt++;
      end
      for (int i = 0; i < 2 * DEPTH && mdl_q.size() > 0; i++) drive(0, '0, 1, 0);
      drive(0, '0, 0, 0);
      total_cnt++; if (empty !== 1'b1) $display("FAIL wrap_empty got %b required 1", empty); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d required 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      drive(1, 64'h31, 0, 0);
      drive(1, 64'h32, 0, 0);
      drive(1, 64'h33, 0, 0);
      pop = 1'b1;
      @(posedge HCLK); #1;
      total_cnt++; if (pop_valid !== 1'b1) $display("FAIL mrst_pv_pre got %b required 1", pop_valid); else pass_cnt++;
      HRESET = 1'b1;
      mdl_q.delete(); exp_q.delete(); mdl_err = 1'b0;
      #1;
      $display("txn t=%0t HRESET asserted with pop pending -> count=%0d pop_valid=%0b", $time, count, pop_valid);
      total_cnt++; if (count !== 4'd0) $display("FAIL mrst_count got %0d required 0", count); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL mrst_empty got %b required 1", empty); else pass_cnt++;
      total_cnt++; if (pop_valid !== 1'b0) $display("FAIL mrst_pv got %b required 0", pop_valid); else pass_cnt++;
      total_cnt++; if (pop_data !== 64'h0) $display("FAIL mrst_data got %h required 0", pop_data); else pass_cnt++;
      pop = 1'b0;
      @(posedge HCLK); #1 HRESET = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_underflow_clear();
      test_wrap();
      test_reset_mid();
      repeat (2) @(posedge HCLK);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
